// File: rtl/shift_seq_ctrl.sv
// Sequencer for the parallel-load / shift-left register: one load strobe, then WIDTH
// shift strobes at a programmable bit rate, with serial clock generation and receive capture.
module shift_seq_ctrl #(
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     tx_data,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 sdi,
    output logic                 sload,
    output logic                 sshift,
    output logic [WIDTH-1:0]     load_data,
    output logic                 sclk,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     rx_data
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] ph_cnt, ph_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0]     rx_sr, rx_sr_n;
    logic                 accept;
    logic                 phase_end;

    assign phase_end = (ph_cnt == div_q);

    always_comb begin
        state_n   = state;
        ph_cnt_n  = ph_cnt;
        bit_cnt_n = bit_cnt;
        rx_sr_n   = rx_sr;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                state_n   = S_SHIFT_LO;
                ph_cnt_n  = '0;
                bit_cnt_n = '0;
            end
            S_SHIFT_LO: begin
                if (phase_end) begin
                    state_n  = S_SHIFT_HI;
                    ph_cnt_n = '0;
                end else begin
                    ph_cnt_n = ph_cnt + DIV_WIDTH'(1);
                end
            end
            S_SHIFT_HI: begin
                if (ph_cnt == '0) begin
                    rx_sr_n = {rx_sr[WIDTH-2:0], sdi};
                end
                if (phase_end) begin
                    ph_cnt_n  = '0;
                    bit_cnt_n = bit_cnt + BW'(1);
                    state_n   = (bit_cnt_n == BW'(WIDTH)) ? S_DONE : S_SHIFT_LO;
                end else begin
                    ph_cnt_n = ph_cnt + DIV_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort && state != S_IDLE) begin
            state_n   = S_IDLE;
            ph_cnt_n  = '0;
            bit_cnt_n = '0;
        end
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            div_q     <= '0;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            sload     <= 1'b0;
            sshift    <= 1'b0;
            sclk      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_data <= '0;
            rx_data   <= '0;
        end else begin
            state   <= state_n;
            ph_cnt  <= ph_cnt_n;
            bit_cnt <= bit_cnt_n;
            rx_sr   <= rx_sr_n;
            sload   <= (state_n == S_LOAD);
            sclk    <= (state_n == S_SHIFT_HI);
            sshift  <= (state_n == S_SHIFT_HI) && (ph_cnt_n == div_q);
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
            if (accept) begin
                load_data <= tx_data;
                div_q     <= div;
            end
            // With div=0 the last sample and the DONE entry share an edge, hence rx_sr_n.
            if (state_n == S_DONE && state != S_DONE) begin
                rx_data <= rx_sr_n;
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized scoreboard bench for shift_seq_ctrl: stimulus pushes the expected strobe
// schedule per transfer, a negedge monitor pops and compares whenever the DUT strobes.
module tb_shift_seq_ctrl;

    localparam int W  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, sdi;
    logic [W-1:0]  tx_data;
    logic [DW-1:0] div;
    logic          sload, sshift, sclk, busy, done;
    logic [W-1:0]  load_data, rx_data;

    shift_seq_ctrl #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tx_data(tx_data),
        .div(div), .sdi(sdi), .sload(sload), .sshift(sshift), .load_data(load_data),
        .sclk(sclk), .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           c;
        logic [W-1:0] v;
    } ev_t;

    ev_t          q_load[$];
    ev_t          q_done[$];
    int           q_shift[$];
    int           cyc = 0;
    int           cur_c0 = -1000, cur_d = 0, cur_done = -1000, cur_last = -1000;
    int           zero_at = -1;
    logic [W-1:0] exp_rx = '0, exp_ld = '0;
    bit           chk_en = 1'b0;
    int           n_cmp = 0, n_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cycle %0d: strobe with no expected entry", name, cyc);
    endtask

    // Monitor: expected busy/sclk derived from the transfer window arithmetic.
    int   m_off, m_p, m_sc;
    logic e_busy, e_sclk;
    ev_t  m_ev;
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == zero_at) begin
                exp_rx = '0;
                exp_ld = '0;
            end
            m_p    = 2 * (cur_d + 1);
            m_off  = cyc - cur_c0 - 2;
            e_busy = (cyc >= cur_c0 + 1) && (cyc <= cur_last);
            e_sclk = e_busy && (m_off >= 0) && (cyc < cur_done) && ((m_off % m_p) >= cur_d + 1);
            check("busy", 32'(busy), 32'(e_busy));
            check("sclk", 32'(sclk), 32'(e_sclk));
            if (sload) begin
                if (q_load.size() == 0) unexpected("sload");
                else begin
                    m_ev = q_load.pop_front();
                    check("sload_cycle", cyc, m_ev.c);
                    exp_ld = m_ev.v;
                end
            end
            if (sshift) begin
                if (q_shift.size() == 0) unexpected("sshift");
                else begin
                    m_sc = q_shift.pop_front();
                    check("sshift_cycle", cyc, m_sc);
                end
            end
            if (done) begin
                if (q_done.size() == 0) unexpected("done");
                else begin
                    m_ev = q_done.pop_front();
                    check("done_cycle", cyc, m_ev.c);
                    exp_rx = m_ev.v;
                end
            end
            check("sload_sshift_excl", 32'(sload && sshift), 32'(0));
            check("rx_data", 32'(rx_data), 32'(exp_rx));
            check("load_data", 32'(load_data), 32'(exp_ld));
        end
    end

    task automatic truncate(input int c);
        cur_last = c;
        while (q_shift.size() > 0 && q_shift[$] > c) void'(q_shift.pop_back());
        while (q_done.size() > 0 && q_done[$].c > c) void'(q_done.pop_back());
        while (q_load.size() > 0 && q_load[$].c > c) void'(q_load.pop_back());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start   = 1'b0;
            abort   = 1'($urandom_range(0, 1));
            rst     = 1'b0;
            tx_data = W'($urandom);
            div     = DW'($urandom);
            sdi     = 1'($urandom);
        end
    endtask

    // One transfer; abort_off/rst_off are cycle offsets from the start cycle (-1 = none).
    task automatic xfer(input int d, input logic [W-1:0] tx, input logic [W-1:0] word,
                        input int abort_off, input int rst_off, input bit noise);
        int  p, o, off;
        ev_t e;
        @(posedge clk); #1;
        start    = 1'b1;
        abort    = 1'b0;
        rst      = 1'b0;
        tx_data  = tx;
        div      = DW'(d);
        p        = 2 * (d + 1);
        cur_c0   = cyc;
        cur_d    = d;
        cur_done = cyc + 2 + W * p;
        cur_last = cur_done;
        e.c = cyc + 1; e.v = tx;
        q_load.push_back(e);
        for (int k = 1; k <= W; k++) q_shift.push_back(cyc + 1 + k * p);
        e.c = cur_done; e.v = word;
        q_done.push_back(e);
        do begin
            @(posedge clk); #1;
            o       = cyc - cur_c0;
            start   = noise && ($urandom_range(0, 7) == 0);
            abort   = 1'b0;
            rst     = 1'b0;
            tx_data = W'($urandom);
            div     = DW'($urandom);
            off     = cyc - cur_c0 - 2;
            if (off >= 0 && off < W * p && (off % p) < d + 1) sdi = word[W - 1 - off / p];
            if (o == abort_off) begin
                abort = 1'b1;
                truncate(cyc);
            end
            if (o == rst_off) begin
                rst     = 1'b1;
                zero_at = cyc + 1;
                truncate(cyc);
            end
        end while (cyc < cur_last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sdi = 1'b0; tx_data = '0; div = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);
        xfer(1, 8'hA5, 8'h3C, -1, -1, 1'b0);
        idle(3);
        xfer(0, W'($urandom), W'($urandom), -1, -1, 1'b1);
        idle(1);
        xfer(1, W'($urandom), W'($urandom), 12, -1, 1'b0);
        idle(1);
        xfer(1, W'($urandom), W'($urandom), -1, -1, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        idle(3);
        xfer((1 << DW) - 1, W'($urandom), W'($urandom), -1, -1, 1'b1);
        idle(1);
        xfer(2, W'($urandom), W'($urandom), -1, 9, 1'b0);
        idle(2);
        repeat (25) begin
            d = $urandom_range(0, 3);
            xfer(d, W'($urandom), W'($urandom),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 1 + W * 2 * (d + 1)) : -1,
                 -1, 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(4);
        check("load_q_empty", q_load.size(), 0);
        check("shift_q_empty", q_shift.size(), 0);
        check("done_q_empty", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
